// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: op codes, FSM states, helpers.
package dmem_pkg;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd7;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, DONE} state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: load extraction/extension, store merge, alignment check.
// DMEM_MISALIGN_TRAP_EN selects trapping instead of masking misaligned low address bits.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [1:0]  eff_lane;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        eff_lane = lane;
        misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (((op == OP_LW) || (op == OP_SW)) && (lane != 2'd0)) ||
                   (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && lane[0]);
`else
        if ((op == OP_LW) || (op == OP_SW))
            eff_lane = 2'd0;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            eff_lane = {lane[1], 1'b0};
`endif
        bsel = word[{eff_lane, 3'b000} +: 8];
        hsel = word[{eff_lane[1], 4'b0000} +: 16];

        case (op)
            OP_LW:   load_data = word;
            OP_LB:   load_data = {{24{bsel[7]}}, bsel};
            OP_LBU:  load_data = {24'h0, bsel};
            OP_LH:   load_data = {{16{hsel[15]}}, hsel};
            OP_LHU:  load_data = {16'h0, hsel};
            default: load_data = '0;
        endcase

        store_word = word;
        case (op)
            OP_SW:   store_word = wdata;
            OP_SH:   store_word[{eff_lane[1], 4'b0000} +: 16] = wdata[15:0];
            OP_SB:   store_word[{eff_lane, 3'b000} +: 8] = wdata[7:0];
            default: store_word = word;
        endcase

        // A trapped access reads as zero and leaves the stored word untouched.
        if (misalign) begin
            load_data  = '0;
            store_word = word;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory for the MEM stage: clear sweep, wait states, req/ready handshake.
// Optional misaligned-access trapping via DMEM_MISALIGN_TRAP_EN (see dmem_lane_unit).
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    state_t state, state_nx;

    logic [AW-1:0]  clr_cnt;
    logic [3:0]     wait_cnt;
    logic [3:0]     op_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    mem [DEPTH_WORDS];

    logic [3:0]     sel_op;
    logic [AW+1:0]  sel_addr;
    logic [31:0]    sel_wdata;
    logic [31:0]    mem_word;
    logic [31:0]    load_data;
    logic [31:0]    store_word;
    logic           lane_mis;
    logic           unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    // In IDLE the live inputs feed the lane unit so a zero-wait access can
    // register its result on the acceptance edge; afterwards the captured copy is used.
    assign sel_op    = (state == IDLE) ? op : op_q;
    assign sel_addr  = (state == IDLE) ? addr[AW+1:0] : addr_q;
    assign sel_wdata = (state == IDLE) ? wdata : wdata_q;
    assign mem_word  = mem[sel_addr[AW+1:2]];

    dmem_lane_unit u_lane (
        .word       (mem_word),
        .op         (sel_op),
        .lane       (sel_addr[1:0]),
        .wdata      (sel_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (lane_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (clr_cnt == LAST_IDX) state_nx = IDLE;
            end
            IDLE: begin
                if (req) state_nx = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == 4'd0) state_nx = DONE;
            end
            DONE: begin
                ready    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    assign misalign = ready & lane_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt  <= '0;
            wait_cnt <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
        end else begin
            if (state == INIT) clr_cnt <= clr_cnt + AW'(1);
            if ((state == IDLE) && req) begin
                op_q     <= op;
                addr_q   <= addr[AW+1:0];
                wdata_q  <= wdata;
                wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state_nx == DONE) rdata <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[clr_cnt] <= '0;
        else if (ready && is_store(op_q) && !lane_mis)
            mem[addr_q[AW+1:2]] <= store_word;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, multi-cycle data memory for the pipelined MIPS core's MEM stage.
- Replaces the single-cycle, fixed 1 K-word data memory.
- Adds configurable depth and wait states, a req/ready handshake the pipeline stalls on, and a post-reset clear sweep.
- Supports byte, halfword and word loads and stores with sign or zero extension, and optional misaligned-access trapping.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 1: extra wait states per access, 0..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  access request; sampled only in IDLE.
- op  in  4  access type; codes from dmem_pkg.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance, or during the clear sweep, until ready.
- misalign  out  1  alignment fault; asserted with ready.

## Operation
- Op codes:
  - LW=0, LB=1, LH=2, LBU=3, LHU=4, SW=5, SH=6, SB=7.
  - Codes 8..15 are NOPs: complete normally with rdata=0 and no write.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap modulo the depth.
- Byte lane is addr[1:0], little-endian: lane 0 is bits [7:0].
- Load extraction:
  - LB/LBU select byte lane 0..3; LH/LHU select halfword 0 (addr[1]=0) or halfword 1.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
- Store merge:
  - SB replaces one byte; SH replaces one halfword; SW replaces the whole word.
  - Untouched lanes keep their stored value. The read-modify-write happens inside the block.
- FSM states: INIT, IDLE, WAIT, DONE.
  - INIT: entered on reset. Writes 0 to one word per cycle, index 0..DEPTH_WORDS-1, then goes to IDLE. busy=1 throughout; req is ignored.
  - IDLE: if req=1, captures op/addr/wdata and goes to WAIT, or straight to DONE when WAIT_CYCLES=0. Captured values are immune to later input changes.
  - WAIT: a counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0 the FSM goes to DONE.
  - DONE: ready=1 and rdata valid. A store commits on the clock edge leaving DONE. Next state is IDLE.
- Requester protocol:
  - Holds req and its operands until ready.
  - Must drop req, or present a new request, in the cycle after ready. A new request in that cycle is accepted, giving back-to-back accesses.
- A load issued after a store to the same word returns the stored data, because the store committed on the edge leaving DONE.
- Reset mid-access aborts the access (no write) and restarts INIT.

## Timing
- Reset values: rdata=0, ready=0, busy=1 (INIT), misalign=0, FSM=INIT, counters=0.
- Clear sweep lasts DEPTH_WORDS cycles after reset deasserts. The first request can be accepted in cycle DEPTH_WORDS.
- Access latency: accepted at edge N, ready=1 during cycle N+WAIT_CYCLES+1.
- busy=1 from cycle N+1 through cycle N+WAIT_CYCLES. busy=0 in DONE, so the stall releases together with ready.
- rdata is registered, holds its value after DONE, and returns to 0 on reset only.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1, completes with misalign=1.
  - rdata=0 and no write occurs; latency is unchanged.
- Undefined:
  - Low address bits are masked: addr[1:0] forced to 0 for word ops, addr[0] forced to 0 for halfword ops.
  - The access proceeds; misalign is tied to 0.

## Structure
- Package dmem_pkg holds:
  - op code localparams and the FSM state enum;
  - a helper function is_store(op).
- Sub-module dmem_lane_unit (combinational) holds:
  - load extraction/extension: word, op, lane → rdata;
  - store merge: old word, wdata, op, lane → new word;
  - the alignment check.
- The top level holds the FSM, wait counter, clear-sweep counter and memory array.

## Test plan
- Reset with DEPTH_WORDS=16: busy=1 for 16 cycles. Then LW at 0x3C → rdata=0x00000000 and ready after WAIT_CYCLES+1 cycles.
- SW 0x8899AABB @0x10, then LB @0x11 → 0xFFFFFFAA; LBU @0x11 → 0x000000AA; LH @0x12 → 0xFFFF8899; LHU @0x10 → 0x0000AABB.
- Over an existing word 0x8899AABB: SB 0x55 @0x13, then SH 0x1234 @0x10, then LW @0x10 → 0x55991234.
- WAIT_CYCLES=0 with back-to-back req (SW then LW, same address) → ready in consecutive accesses with no idle gap; LW returns the stored value.
- LW @0x02: with the macro → misalign=1, rdata=0. Without the macro → returns the word at 0x00, misalign=0.
- Assert rst during WAIT of an SW 0xDEADBEEF @0x04 → no write. After the sweep, LW @0x04 → 0.
